// File: rtl/mastermind_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mastermind_pkg
// Description : State encoding and sizing helper shared by the Mastermind
//               scorer, the input FSM and the display logic.
// Revision    : 1.0  initial release
// ============================================================================
package mastermind_pkg;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_READY  = 3'd1;
    localparam logic [2:0] S_RED    = 3'd2;
    localparam logic [2:0] S_WHITE  = 3'd3;
    localparam logic [2:0] S_REPORT = 3'd4;
    localparam logic [2:0] S_OVER   = 3'd5;

    // Bits needed to hold values 0..value-1 (ceil log2).
    function automatic int clog2_f(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mastermind_first_match.sv
`default_nettype none
// ============================================================================
// Module      : mastermind_first_match
// Description : Finds the lowest code peg of a given colour not yet consumed
//               by an earlier match.
// Revision    : 1.0  initial release
// ============================================================================
module mastermind_first_match #(
    parameter int N_PEGS  = 4,
    parameter int COLOR_W = 3,
    parameter int IDX_W   = 2
) (
    input  logic [COLOR_W-1:0]        colour,
    input  logic [N_PEGS*COLOR_W-1:0] code,
    input  logic [N_PEGS-1:0]         code_match,
    output logic                      found,
    output logic [IDX_W-1:0]          index
);

    // Scan from the top so the lowest qualifying index is the one that sticks.
    always_comb begin
        found = 1'b0;
        index = '0;
        for (int i = N_PEGS - 1; i >= 0; i--) begin
            if (!code_match[i] && (code[i*COLOR_W +: COLOR_W] == colour)) begin
                found = 1'b1;
                index = IDX_W'(i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mastermind_scorer.sv
`default_nettype none
// ============================================================================
// Module      : mastermind_scorer
// Description : Sequential Mastermind scoring engine: red pass, then white
//               pass with duplicate-aware matching, then report/game state.
// Revision    : 1.0  initial release
// ============================================================================
module mastermind_scorer
    import mastermind_pkg::*;
#(
    parameter int N_PEGS      = 4,
    parameter int COLOR_W     = 3,
    parameter int MAX_GUESSES = 8,
    localparam int CNT_W      = clog2_f(N_PEGS + 1),
    localparam int GC_W       = clog2_f(MAX_GUESSES + 1)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      code_load,
    input  logic [N_PEGS*COLOR_W-1:0] code_in,
    input  logic                      guess_valid,
    output logic                      guess_ready,
    input  logic [N_PEGS*COLOR_W-1:0] guess_in,
    output logic                      score_valid,
    output logic [CNT_W-1:0]          red,
    output logic [CNT_W-1:0]          white,
    output logic                      win,
    output logic                      game_over,
    output logic [GC_W-1:0]           guess_count
);

    localparam int IDX_W = clog2_f(N_PEGS);

    logic [2:0]                  r_state;
    logic [2:0]                  w_state_nxt;
    logic [N_PEGS*COLOR_W-1:0]   r_code;
    logic [N_PEGS*COLOR_W-1:0]   r_guess;
    logic [N_PEGS-1:0]           r_code_match;
    logic [N_PEGS-1:0]           r_guess_match;
    logic [IDX_W-1:0]            r_idx;
    logic [CNT_W-1:0]            r_red_cnt;
    logic [CNT_W-1:0]            r_white_cnt;
    logic [CNT_W-1:0]            r_red;
    logic [CNT_W-1:0]            r_white;
    logic                        r_win;
    logic                        r_game_over;
    logic                        r_score_valid;
    logic [GC_W-1:0]             r_guess_count;

    logic                        w_accept;
    logic                        w_last_idx;
    logic                        w_is_win;
    logic                        w_last_guess;
    logic [COLOR_W-1:0]          w_code_peg;
    logic [COLOR_W-1:0]          w_guess_peg;
    logic                        w_found;
    logic [IDX_W-1:0]            w_fidx;

    assign guess_ready  = (r_state == S_READY) && !code_load;
    assign w_accept     = guess_valid && guess_ready;
    assign w_last_idx   = (r_idx == IDX_W'(N_PEGS - 1));
    assign w_is_win     = (r_red_cnt == CNT_W'(N_PEGS));
    assign w_last_guess = (r_guess_count == GC_W'(MAX_GUESSES - 1));

    always_comb begin
        w_code_peg  = '0;
        w_guess_peg = '0;
        for (int i = 0; i < N_PEGS; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_code_peg  = r_code[i*COLOR_W +: COLOR_W];
                w_guess_peg = r_guess[i*COLOR_W +: COLOR_W];
            end
        end
    end

    mastermind_first_match #(
        .N_PEGS  (N_PEGS),
        .COLOR_W (COLOR_W),
        .IDX_W   (IDX_W)
    ) u_first_match (
        .colour     (w_guess_peg),
        .code       (r_code),
        .code_match (r_code_match),
        .found      (w_found),
        .index      (w_fidx)
    );

    always_comb begin
        w_state_nxt = r_state;
        if (code_load) begin
            w_state_nxt = S_READY;
        end else begin
            case (r_state)
                S_READY:  if (w_accept)   w_state_nxt = S_RED;
                S_RED:    if (w_last_idx) w_state_nxt = S_WHITE;
                S_WHITE:  if (w_last_idx) w_state_nxt = S_REPORT;
                S_REPORT: w_state_nxt = (w_is_win || w_last_guess) ? S_OVER : S_READY;
                S_IDLE:   w_state_nxt = S_IDLE;
                S_OVER:   w_state_nxt = S_OVER;
                default:  w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_code        <= '0;
            r_guess       <= '0;
            r_code_match  <= '0;
            r_guess_match <= '0;
            r_idx         <= '0;
            r_red_cnt     <= '0;
            r_white_cnt   <= '0;
            r_red         <= '0;
            r_white       <= '0;
            r_win         <= 1'b0;
            r_game_over   <= 1'b0;
            r_score_valid <= 1'b0;
            r_guess_count <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_score_valid <= 1'b0;
            if (code_load) begin
                // New game: any in-flight scoring is abandoned silently.
                r_code        <= code_in;
                r_code_match  <= '0;
                r_guess_match <= '0;
                r_idx         <= '0;
                r_red_cnt     <= '0;
                r_white_cnt   <= '0;
                r_red         <= '0;
                r_white       <= '0;
                r_win         <= 1'b0;
                r_game_over   <= 1'b0;
                r_guess_count <= '0;
            end else begin
                case (r_state)
                    S_READY: begin
                        if (w_accept) begin
                            r_guess       <= guess_in;
                            r_code_match  <= '0;
                            r_guess_match <= '0;
                            r_idx         <= '0;
                            r_red_cnt     <= '0;
                            r_white_cnt   <= '0;
                        end
                    end
                    S_RED: begin
                        if (w_code_peg == w_guess_peg) begin
                            r_red_cnt            <= r_red_cnt + CNT_W'(1);
                            r_code_match[r_idx]  <= 1'b1;
                            r_guess_match[r_idx] <= 1'b1;
                        end
                        r_idx <= w_last_idx ? '0 : r_idx + IDX_W'(1);
                    end
                    S_WHITE: begin
                        // Exact matches already consumed both pegs in the red pass.
                        if (!r_guess_match[r_idx] && w_found) begin
                            r_white_cnt          <= r_white_cnt + CNT_W'(1);
                            r_code_match[w_fidx] <= 1'b1;
                        end
                        r_idx <= w_last_idx ? '0 : r_idx + IDX_W'(1);
                    end
                    S_REPORT: begin
                        r_red         <= r_red_cnt;
                        r_white       <= r_white_cnt;
                        r_score_valid <= 1'b1;
                        r_guess_count <= r_guess_count + GC_W'(1);
                        r_win         <= w_is_win;
                        r_game_over   <= w_is_win || w_last_guess;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign score_valid = r_score_valid;
    assign red         = r_red;
    assign white       = r_white;
    assign win         = r_win;
    assign game_over   = r_game_over;
    assign guess_count = r_guess_count;

endmodule
`default_nettype wire

// File: tb/tb_mastermind_scorer.sv
`default_nettype none
// ============================================================================
// Module      : tb_mastermind_scorer
// Description : Self-checking bench: vector table plus scoreboard of expected
//               scores, with hand sequences for abort/reset/game-over cases.
// Revision    : 1.0  initial release
// ============================================================================
module tb_mastermind_scorer;

    logic        clk = 1'b0;
    logic        reset;
    logic        code_load;
    logic [11:0] code_in;
    logic        guess_valid;
    logic        guess_ready;
    logic [11:0] guess_in;
    logic        score_valid;
    logic [2:0]  red;
    logic [2:0]  white;
    logic        win;
    logic        game_over;
    logic [3:0]  guess_count;

    mastermind_scorer #(
        .N_PEGS      (4),
        .COLOR_W     (3),
        .MAX_GUESSES (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .code_load   (code_load),
        .code_in     (code_in),
        .guess_valid (guess_valid),
        .guess_ready (guess_ready),
        .guess_in    (guess_in),
        .score_valid (score_valid),
        .red         (red),
        .white       (white),
        .win         (win),
        .game_over   (game_over),
        .guess_count (guess_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        int red;
        int white;
        int win;
        int go;
        int gc;
        int acc;
    } exp_t;

    typedef struct {
        bit          load;
        logic [11:0] code;
        logic [11:0] guess;
        int          red;
        int          white;
        int          win;
        int          go;
        int          gc;
    } vec_t;

    exp_t sb[$];
    exp_t e_mon;

    function automatic logic [11:0] pk(input int a, input int b, input int c, input int d);
        return {3'(d), 3'(c), 3'(b), 3'(a)};
    endfunction

    task automatic chk(input string name, input int act, input int req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (score_valid === 1'b1) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_score: got score_valid=1 at cycle %0d, expected none", cyc);
            end else begin
                e_mon = sb.pop_front();
                chk("red", int'(red), e_mon.red);
                chk("white", int'(white), e_mon.white);
                chk("win", int'(win), e_mon.win);
                chk("game_over", int'(game_over), e_mon.go);
                chk("guess_count", int'(guess_count), e_mon.gc);
                chk("latency", cyc - e_mon.acc, 9);
            end
        end
    end

    task automatic load(input logic [11:0] c);
        @(negedge clk);
        code_load = 1'b1;
        code_in   = c;
        @(negedge clk);
        code_load = 1'b0;
    endtask

    task automatic accept(input logic [11:0] g, output bit ok, output int acc);
        ok          = 1'b0;
        acc         = 0;
        guess_in    = g;
        guess_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (guess_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (ok) begin
            @(posedge clk);
            #1;
            acc = cyc;
        end else begin
            n_vec++;
            n_err++;
            $display("FAIL accept: got guess_ready=0 for 20 cycles, expected 1");
        end
        guess_valid = 1'b0;
    endtask

    task automatic play(input logic [11:0] g, input int r, input int w,
                        input int wn, input int go, input int gc);
        bit   ok;
        int   acc;
        exp_t e;
        accept(g, ok, acc);
        if (ok) begin
            e = '{r, w, wn, go, gc, acc};
            sb.push_back(e);
            for (int i = 0; i < 30; i++) begin
                if (sb.size() == 0) break;
                @(posedge clk);
            end
            if (sb.size() != 0) begin
                n_vec++;
                n_err++;
                $display("FAIL score_timeout: got no score_valid in 30 cycles, expected one");
                sb.delete();
            end
        end
        @(negedge clk);
    endtask

    task automatic ready_high_cycles(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            #1;
            if (guess_ready !== 1'b0) cnt++;
        end
    endtask

    vec_t tbl[7];
    bit   ok;
    int   acc;
    int   cnt;

    initial begin
        tbl[0] = '{1'b1, pk(1,2,3,4), pk(1,2,3,4), 4, 0, 1, 1, 1};
        tbl[1] = '{1'b1, pk(1,1,2,2), pk(2,2,1,1), 0, 4, 0, 0, 1};
        tbl[2] = '{1'b1, pk(1,2,3,4), pk(4,3,2,0), 0, 3, 0, 0, 1};
        tbl[3] = '{1'b1, pk(1,1,2,3), pk(1,1,1,1), 2, 0, 0, 0, 1};
        tbl[4] = '{1'b0, pk(1,1,2,3), pk(3,3,1,5), 0, 2, 0, 0, 2};
        tbl[5] = '{1'b1, pk(1,2,3,4), pk(1,3,2,4), 2, 2, 0, 0, 1};
        tbl[6] = '{1'b0, pk(1,2,3,4), pk(5,5,5,5), 0, 0, 0, 0, 2};

        reset       = 1'b1;
        code_load   = 1'b0;
        code_in     = '0;
        guess_valid = 1'b0;
        guess_in    = '0;
        repeat (2) @(negedge clk);
        chk("rst_red", int'(red), 0);
        chk("rst_white", int'(white), 0);
        chk("rst_win", int'(win), 0);
        chk("rst_game_over", int'(game_over), 0);
        chk("rst_guess_count", int'(guess_count), 0);
        chk("rst_score_valid", int'(score_valid), 0);
        reset = 1'b0;
        ready_high_cycles(3, cnt);
        chk("idle_ready_cycles", cnt, 0);

        for (int i = 0; i < 7; i++) begin
            if (tbl[i].load) load(tbl[i].code);
            play(tbl[i].guess, tbl[i].red, tbl[i].white, tbl[i].win, tbl[i].go, tbl[i].gc);
        end

        // After a win the engine must refuse further guesses.
        load(pk(1,2,3,4));
        play(pk(1,2,3,4), 4, 0, 1, 1, 1);
        ready_high_cycles(5, cnt);
        chk("ready_after_win_cycles", cnt, 0);

        // Guess budget exhaustion.
        load(pk(1,2,3,4));
        for (int k = 1; k <= 8; k++) begin
            play(pk(0,0,0,0), 0, 0, 0, (k == 8) ? 1 : 0, k);
        end
        guess_valid = 1'b1;
        guess_in    = pk(1,2,3,4);
        ready_high_cycles(12, cnt);
        guess_valid = 1'b0;
        chk("ready_after_budget_cycles", cnt, 0);

        // code_load while the red pass is in progress.
        load(pk(1,2,3,4));
        play(pk(1,2,3,0), 3, 0, 0, 0, 1);
        accept(pk(1,2,3,4), ok, acc);
        repeat (2) @(posedge clk);
        @(negedge clk);
        code_load = 1'b1;
        code_in   = pk(7,7,7,7);
        @(posedge clk);
        #1;
        chk("abort_red", int'(red), 0);
        chk("abort_white", int'(white), 0);
        chk("abort_guess_count", int'(guess_count), 0);
        chk("abort_score_valid", int'(score_valid), 0);
        @(negedge clk);
        code_load = 1'b0;
        #1;
        chk("abort_ready", int'(guess_ready), 1);
        repeat (12) @(negedge clk);
        play(pk(7,7,7,7), 4, 0, 1, 1, 1);

        // Asynchronous reset in the middle of the white pass.
        load(pk(1,2,3,4));
        play(pk(1,2,3,0), 3, 0, 0, 0, 1);
        accept(pk(1,2,3,4), ok, acc);
        repeat (6) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("areset_red", int'(red), 0);
        chk("areset_guess_count", int'(guess_count), 0);
        chk("areset_ready", int'(guess_ready), 0);
        chk("areset_score_valid", int'(score_valid), 0);
        @(negedge clk);
        reset = 1'b0;
        ready_high_cycles(4, cnt);
        chk("ready_after_reset_cycles", cnt, 0);

        // code_load and guess_valid together: only the code is taken.
        @(negedge clk);
        code_load   = 1'b1;
        code_in     = pk(5,5,5,5);
        guess_valid = 1'b1;
        guess_in    = pk(0,0,0,0);
        #1;
        chk("load_guess_ready", int'(guess_ready), 0);
        @(negedge clk);
        code_load   = 1'b0;
        guess_valid = 1'b0;
        #1;
        chk("post_load_ready", int'(guess_ready), 1);
        repeat (12) @(negedge clk);
        play(pk(5,5,5,5), 4, 0, 1, 1, 1);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
